// File: rtl/rs_arb_pkg.sv
// Shared definitions for the round-robin request arbiter: FSM encoding,
// default sizing and the modulo-N pointer helper.
package rs_arb_pkg;

   localparam int DEF_N   = 4;
   localparam int DEF_TMO = 15;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_e;

   // (base + ofs) mod n. Both operands are below n (n <= 8), so the sum
   // fits in 4 bits and a single subtraction wraps it.
   function automatic logic [2:0] rr_wrap(input logic [2:0] base,
                                          input logic [2:0] ofs,
                                          input int         n);
      logic [3:0] sum;
      sum = {1'b0, base} + {1'b0, ofs};
      if (sum >= 4'(n)) begin
         sum = sum - 4'(n);
      end
      return sum[2:0];
   endfunction

endpackage

// File: rtl/rs_req_arbiter_if.sv
// Request/grant bundle between N requesters and the arbiter.
// Requester side drives S/R/DONE, arbiter side drives everything else.
//   Handshake: S[i] is a one-cycle set pulse that raises pending flag i;
//   R[i] is a one-cycle reset pulse that withdraws it (or aborts an active
//   grant). GNT is one-hot and stays stable while BUSY=1; the resource
//   ends the grant with a one-cycle DONE, after which GNT drops for one
//   RELEASE cycle before the next arbitration. GNT_ID is meaningful only
//   while BUSY=1.
interface rs_req_arbiter_if
   import rs_arb_pkg::*;
#(
   parameter int N = DEF_N
) ();

   logic [N-1:0] S;
   logic [N-1:0] R;
   logic         DONE;
   logic [N-1:0] GNT;
   logic [2:0]   GNT_ID;
   logic         BUSY;
   logic [N-1:0] PEND;
   logic [N-1:0] PEND_B;
   logic [N-1:0] ILLEGAL;
   logic         TMO_ERR;

   modport master (
      output S, R, DONE,
      input  GNT, GNT_ID, BUSY, PEND, PEND_B, ILLEGAL, TMO_ERR
   );

   modport slave (
      input  S, R, DONE,
      output GNT, GNT_ID, BUSY, PEND, PEND_B, ILLEGAL, TMO_ERR
   );

endinterface

// File: rtl/rs_flag_cell.sv
// One registered RS element: Q and Q_B are independent flops so that the
// S=R=1 case is visible as Q=Q_B=0, with a sticky ILL flag.
module rs_flag_cell (
   input  logic CLK,
   input  logic RST_N,
   input  logic S,
   input  logic R,
   output logic Q,
   output logic Q_B,
   output logic ILL
);

   logic q_q,   q_d;
   logic qb_q,  qb_d;
   logic ill_q, ill_d;

   always_comb begin
      q_d   = q_q;
      qb_d  = qb_q;
      ill_d = ill_q;
      case ({S, R})
         2'b10: begin
            q_d  = 1'b1;
            qb_d = 1'b0;
         end
         2'b01: begin
            q_d  = 1'b0;
            qb_d = 1'b1;
         end
         2'b11: begin
            q_d   = 1'b0;
            qb_d  = 1'b0;
            ill_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         q_q   <= 1'b0;
         qb_q  <= 1'b1;
         ill_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         qb_q  <= qb_d;
         ill_q <= ill_d;
      end
   end

   assign Q   = q_q;
   assign Q_B = qb_q;
   assign ILL = ill_q;

   a_never_both_set: assert property (@(posedge CLK) disable iff (!RST_N)
      !(q_q && qb_q));

endmodule

// File: rtl/rs_req_arbiter.sv
// Round-robin arbiter over N RS-style pending flags with grant timeout,
// abort via R[grantee] and a one-cycle RELEASE between grants.
module rs_req_arbiter
   import rs_arb_pkg::*;
#(
   parameter int N   = DEF_N,
   parameter int TMO = DEF_TMO
) (
   input  logic             CLK,
   input  logic             RST_N,
   rs_req_arbiter_if.slave  bus,
   output arb_state_e       dbg_state_o,
   output logic [2:0]       dbg_ptr_o
);

   arb_state_e   state_q, state_d;
   logic [N-1:0] gnt_q,   gnt_d;
   logic [2:0]   gid_q,   gid_d;
   logic [7:0]   cnt_q,   cnt_d;
   logic [2:0]   ptr_q,   ptr_d;
   logic         tmo_err_q, tmo_err_d;

   logic [N-1:0] pend;
   logic [N-1:0] pend_b;
   logic [N-1:0] ill;
   logic [N-1:0] gnt_mask;
   logic [N-1:0] r_eff;
   logic [7:0]   req_ext;
   logic         sel_found;
   logic [2:0]   sel_idx;
   logic         abort;
   logic         expire;

   // In RELEASE the grantee's flag is cleared through its R input, unless
   // the requester sets it again in that same cycle.
   assign gnt_mask = N'(1) << gid_q;
   assign r_eff    = bus.R | ((state_q == ST_RELEASE) ? (gnt_mask & ~bus.S) : '0);

   for (genvar i = 0; i < N; i++) begin : g_flag
      rs_flag_cell u_flag (
         .CLK   (CLK),
         .RST_N (RST_N),
         .S     (bus.S[i]),
         .R     (r_eff[i]),
         .Q     (pend[i]),
         .Q_B   (pend_b[i]),
         .ILL   (ill[i])
      );
   end

   // A flag being withdrawn this cycle is not a candidate for arbitration.
   assign req_ext = 8'(pend & ~bus.R);

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = 0; k < N; k++) begin
         logic [2:0] idx;
         idx = rr_wrap(ptr_q, 3'(k), N);
         if (!sel_found && req_ext[idx]) begin
            sel_found = 1'b1;
            sel_idx   = idx;
         end
      end
   end

   assign abort  = |(bus.R & gnt_q);
   assign expire = (cnt_q == 8'(TMO - 1));

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gid_d     = gid_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      tmo_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sel_found) begin
               state_d = ST_GRANT;
               gnt_d   = N'(1) << sel_idx;
               gid_d   = sel_idx;
               cnt_d   = '0;
            end
         end
         ST_GRANT: begin
            // DONE takes precedence over a coincident expiry.
            if (bus.DONE || abort || expire) begin
               state_d   = ST_RELEASE;
               gnt_d     = '0;
               tmo_err_d = expire && !bus.DONE && !abort;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
            ptr_d   = rr_wrap(gid_q, 3'd1, N);
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         gid_q     <= '0;
         cnt_q     <= '0;
         ptr_q     <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gid_q     <= gid_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   assign bus.GNT     = gnt_q;
   assign bus.GNT_ID  = gid_q;
   assign bus.BUSY    = (state_q == ST_GRANT);
   assign bus.PEND    = pend;
   assign bus.PEND_B  = pend_b;
   assign bus.ILLEGAL = ill;
   assign bus.TMO_ERR = tmo_err_q;

   assign dbg_state_o = state_q;
   assign dbg_ptr_o   = ptr_q;

   a_gnt_onehot0: assert property (@(posedge CLK) disable iff (!RST_N)
      $onehot0(gnt_q));
   a_busy_has_gnt: assert property (@(posedge CLK) disable iff (!RST_N)
      (state_q == ST_GRANT) |-> (gnt_q != '0));

endmodule

// File: tb/tb_rs_req_arbiter.sv
// Bench for rs_req_arbiter: a vector table for the single-cycle RS and
// arbitration behaviour, then hand sequences for multi-cycle grant cases.
module tb_rs_req_arbiter;
   import rs_arb_pkg::*;

   logic       CLK;
   logic       RST_N;
   arb_state_e dbg_state;
   logic [2:0] dbg_ptr;

   rs_req_arbiter_if #(.N(4)) bus ();

   rs_req_arbiter #(.N(4), .TMO(15)) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .bus         (bus),
      .dbg_state_o (dbg_state),
      .dbg_ptr_o   (dbg_ptr)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int         n_checks = 0;
   int         n_fail   = 0;
   bit         sb_en    = 1'b0;
   logic [2:0] exp_q[$];

   typedef struct {
      logic [3:0] s;
      logic [3:0] r;
      logic       done;
      logic [3:0] pend;
      logic [3:0] pend_b;
      logic [3:0] gnt;
      logic [3:0] ill;
      logic [2:0] gid;
      logic       busy;
      logic [1:0] st;
      logic [2:0] ptr;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic reset_dut();
      RST_N    = 1'b0;
      bus.S    = '0;
      bus.R    = '0;
      bus.DONE = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST_N = 1'b1;
   endtask

   task automatic wait_busy(input string name);
      int i;
      i = 0;
      while (!bus.BUSY && i < 40) begin
         cycle();
         i++;
      end
      n_checks++;
      if (!bus.BUSY) begin
         n_fail++;
         $display("FAIL %s: no grant within 40 cycles", name);
      end
   endtask

   // Scoreboard: each rising BUSY must match the oldest expected grantee.
   initial begin : monitor
      logic       prev_busy;
      logic [2:0] e;
      logic [3:0] eg;
      prev_busy = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         if (sb_en) begin
            check("gnt_onehot0", 32'($onehot0(bus.GNT)), 32'd1);
            if (bus.BUSY && !prev_busy) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL sb_unexpected_grant: got GNT_ID %0d expected no grant", bus.GNT_ID);
               end else begin
                  e  = exp_q.pop_front();
                  eg = 4'b0001 << e;
                  check("sb_gnt_id", 32'(bus.GNT_ID), 32'(e));
                  check("sb_gnt", 32'(bus.GNT), 32'(eg));
               end
            end
         end
         prev_busy = bus.BUSY;
      end
   end

   initial begin : main
      int cycles;
      vecs[0]  = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 3'd0, 1'b0, 2'd0, 3'd0};
      vecs[1]  = '{4'b0000, 4'b0000, 1'b0, 4'b0100, 4'b1011, 4'b0100, 4'b0000, 3'd2, 1'b1, 2'd1, 3'd0};
      vecs[2]  = '{4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 3'd0, 1'b0, 2'd2, 3'd0};
      vecs[3]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 3'd0, 1'b0, 2'd0, 3'd3};
      vecs[4]  = '{4'b0010, 4'b0010, 1'b0, 4'b0000, 4'b1101, 4'b0000, 4'b0010, 3'd0, 1'b0, 2'd0, 3'd3};
      vecs[5]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1101, 4'b0000, 4'b0010, 3'd0, 1'b0, 2'd0, 3'd3};
      vecs[6]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b1101, 4'b0000, 4'b0010, 3'd0, 1'b0, 2'd0, 3'd3};
      vecs[7]  = '{4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b1101, 4'b0010, 4'b0010, 3'd1, 1'b1, 2'd1, 3'd3};
      vecs[8]  = '{4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b1101, 4'b0000, 4'b0010, 3'd0, 1'b0, 2'd2, 3'd3};
      vecs[9]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0010, 3'd0, 1'b0, 2'd0, 3'd2};
      vecs[10] = '{4'b1000, 4'b0000, 1'b0, 4'b1000, 4'b0111, 4'b0000, 4'b0010, 3'd0, 1'b0, 2'd0, 3'd2};
      vecs[11] = '{4'b0000, 4'b1000, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0010, 3'd0, 1'b0, 2'd0, 3'd2};
      vecs[12] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0010, 3'd0, 1'b0, 2'd0, 3'd2};

      reset_dut();
      check("rst_gnt",    32'(bus.GNT),     32'd0);
      check("rst_busy",   32'(bus.BUSY),    32'd0);
      check("rst_pend",   32'(bus.PEND),    32'd0);
      check("rst_pend_b", 32'(bus.PEND_B),  32'hf);
      check("rst_ill",    32'(bus.ILLEGAL), 32'd0);
      check("rst_tmo",    32'(bus.TMO_ERR), 32'd0);
      check("rst_state",  32'(dbg_state),   32'd0);
      check("rst_ptr",    32'(dbg_ptr),     32'd0);

      for (int v = 0; v < 13; v++) begin
         bus.S    = vecs[v].s;
         bus.R    = vecs[v].r;
         bus.DONE = vecs[v].done;
         cycle();
         check($sformatf("v%0d_pend", v),   32'(bus.PEND),    32'(vecs[v].pend));
         check($sformatf("v%0d_pend_b", v), 32'(bus.PEND_B),  32'(vecs[v].pend_b));
         check($sformatf("v%0d_gnt", v),    32'(bus.GNT),     32'(vecs[v].gnt));
         check($sformatf("v%0d_ill", v),    32'(bus.ILLEGAL), 32'(vecs[v].ill));
         check($sformatf("v%0d_busy", v),   32'(bus.BUSY),    32'(vecs[v].busy));
         check($sformatf("v%0d_state", v),  32'(dbg_state),   32'(vecs[v].st));
         check($sformatf("v%0d_ptr", v),    32'(dbg_ptr),     32'(vecs[v].ptr));
         if (vecs[v].busy) begin
            check($sformatf("v%0d_gid", v), 32'(bus.GNT_ID), 32'(vecs[v].gid));
         end
      end
      bus.S    = '0;
      bus.R    = '0;
      bus.DONE = 1'b0;

      // All four request at once: served 0,1,2,3, each exactly once.
      reset_dut();
      check("a_ill_cleared", 32'(bus.ILLEGAL), 32'd0);
      sb_en = 1'b1;
      for (int k = 0; k < 4; k++) exp_q.push_back(3'(k));
      bus.S = 4'b1111;
      cycle();
      bus.S = '0;
      for (int k = 0; k < 4; k++) begin
         wait_busy("a_wait");
         bus.DONE = 1'b1;
         cycle();
         bus.DONE = 1'b0;
      end
      repeat (6) cycle();
      check("a_queue_empty", 32'(exp_q.size()), 32'd0);
      check("a_pend", 32'(bus.PEND), 32'd0);
      check("a_busy", 32'(bus.BUSY), 32'd0);

      // Timeout: 15 GRANT cycles, TMO_ERR only in RELEASE.
      reset_dut();
      exp_q.push_back(3'd0);
      bus.S = 4'b0001;
      cycle();
      bus.S = '0;
      wait_busy("b_wait");
      cycles = 1;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (!bus.BUSY) break;
         check("b_tmo_early", 32'(bus.TMO_ERR), 32'd0);
         cycles++;
      end
      check("b_grant_cycles", 32'(cycles), 32'd15);
      check("b_tmo_pulse", 32'(bus.TMO_ERR), 32'd1);
      check("b_release", 32'(dbg_state), 32'd2);
      cycle();
      check("b_tmo_cleared", 32'(bus.TMO_ERR), 32'd0);
      check("b_ptr", 32'(dbg_ptr), 32'd1);
      check("b_pend", 32'(bus.PEND), 32'd0);
      check("b_idle", 32'(dbg_state), 32'd0);

      // Abort via R[0]; S[0] in RELEASE re-queues; S[0] during GRANT is absorbed.
      reset_dut();
      exp_q.push_back(3'd0);
      bus.S = 4'b0001;
      cycle();
      bus.S = '0;
      wait_busy("c_wait1");
      bus.R = 4'b0001;
      cycle();
      bus.R = '0;
      check("c_abort_busy", 32'(bus.BUSY), 32'd0);
      check("c_abort_state", 32'(dbg_state), 32'd2);
      check("c_abort_pend", 32'(bus.PEND), 32'd0);
      check("c_abort_tmo", 32'(bus.TMO_ERR), 32'd0);
      exp_q.push_back(3'd0);
      bus.S = 4'b0001;
      cycle();
      bus.S = '0;
      check("c_requeue_pend", 32'(bus.PEND), 32'd1);
      check("c_requeue_state", 32'(dbg_state), 32'd0);
      wait_busy("c_wait2");
      bus.S = 4'b0001;
      cycle();
      bus.S = '0;
      check("c_set_in_grant_pend", 32'(bus.PEND), 32'd1);
      check("c_set_in_grant_busy", 32'(bus.BUSY), 32'd1);
      bus.DONE = 1'b1;
      cycle();
      bus.DONE = 1'b0;
      check("c_done_release", 32'(dbg_state), 32'd2);
      cycle();
      check("c_final_pend", 32'(bus.PEND), 32'd0);
      check("c_final_pend_b", 32'(bus.PEND_B), 32'hf);
      check("c_final_ptr", 32'(dbg_ptr), 32'd1);
      repeat (4) cycle();
      check("c_no_regrant", 32'(bus.BUSY), 32'd0);
      check("c_queue_empty", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset in the middle of a grant.
      reset_dut();
      exp_q.push_back(3'd0);
      bus.S = 4'b0011;
      cycle();
      bus.S = '0;
      wait_busy("d_wait");
      #2 RST_N = 1'b0;
      #1;
      check("d_gnt", 32'(bus.GNT), 32'd0);
      check("d_busy", 32'(bus.BUSY), 32'd0);
      check("d_pend", 32'(bus.PEND), 32'd0);
      check("d_pend_b", 32'(bus.PEND_B), 32'hf);
      check("d_state", 32'(dbg_state), 32'd0);
      check("d_ptr", 32'(dbg_ptr), 32'd0);
      check("d_queue_empty", 32'(exp_q.size()), 32'd0);
      reset_dut();
      repeat (4) cycle();
      check("d_requests_lost", 32'(bus.BUSY), 32'd0);
      sb_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rs_req_arbiter.md
RS_REQ_ARBITER -- requirements
Module: rs_req_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters (2..8).
REQ-002 Parameter TMO, default 15, grant timeout in cycles (1..255).
REQ-003 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 RST_N  input  1  reset, asynchronous and active-low.
REQ-005 S  input  N  per-requester set pulse; raises the pending request.
REQ-006 R  input  N  per-requester reset pulse; withdraws the pending request or aborts the grant.
REQ-007 DONE  input  1  resource finished with the current grantee.
REQ-008 GNT  output  N  one-hot grant, registered.
REQ-009 GNT_ID  output  3  binary index of the current grantee; valid only while BUSY=1.
REQ-010 BUSY  output  1  high in GRANT state.
REQ-011 PEND  output  N  registered pending flags (Q of each RS element).
REQ-012 PEND_B  output  N  independent registered complement flags; never both 0 with PEND except after an illegal event.
REQ-013 ILLEGAL  output  N  sticky flag, set when S[i]=R[i]=1 in the same cycle.
REQ-014 TMO_ERR  output  1  one-cycle pulse on grant timeout.

Function
REQ-015 Pending flag i SHALL follow the RS table each cycle: S=1,R=0 -> PEND=1,PEND_B=0; S=0,R=1 -> PEND=0,PEND_B=1; S=R=0 -> hold; S=R=1 -> PEND=0,PEND_B=0, ILLEGAL[i]<=1.
REQ-016 A pending flag in the illegal state (PEND=PEND_B=0) SHALL be recovered only by a later legal S or R pulse.
REQ-017 The FSM SHALL have states IDLE, GRANT, RELEASE.
REQ-018 IDLE: if any PEND=1, pick the first set PEND at or after the round-robin pointer PTR, then go to GRANT next cycle with GNT/GNT_ID/BUSY registered; otherwise stay in IDLE.
REQ-019 Latency from S[i] (in IDLE, no other pending) to GNT[i]=1 SHALL be 2 cycles: PEND rises at edge 1, GNT rises at edge 2.
REQ-020 GRANT: GNT is held stable and the timeout counter increments each cycle from 0.
REQ-021 GRANT -> RELEASE on DONE=1, or on R[grantee]=1 (abort), or when the counter reaches TMO-1 without DONE (TMO_ERR pulses in the RELEASE cycle).
REQ-022 RELEASE (one cycle): GNT=0, BUSY=0; clear PEND of the grantee (PEND_B=1) unless S[grantee]=1 in that cycle (set wins, request re-queued); PTR <= grantee+1 modulo N; go to IDLE.
REQ-023 DONE in IDLE or RELEASE SHALL be ignored.
REQ-024 S/R on non-granted requesters SHALL be processed per REQ-015 in every state; a request withdrawn before arbitration SHALL never be granted.
REQ-025 S[grantee] during GRANT SHALL leave PEND=1 and not extend the grant.
REQ-026 Simultaneous DONE and counter expiry SHALL count as DONE (no TMO_ERR).
REQ-027 GNT SHALL be zero or one-hot in every cycle.

Reset
REQ-028 RST_N=0 SHALL immediately force: state IDLE, GNT=0, GNT_ID=0, BUSY=0, PEND=0, PEND_B=all ones, ILLEGAL=0, TMO_ERR=0, PTR=0, counter=0.
REQ-029 Reset mid-grant SHALL drop GNT asynchronously; no RELEASE cycle occurs and all requests are lost.
REQ-030 ILLEGAL SHALL clear only on reset.

Structure
REQ-031 The state encoding (IDLE=0, GRANT=1, RELEASE=2) and the default N and TMO SHALL live in the shared package rs_arb_pkg.
REQ-032 The per-requester flag SHALL be the sub-module rs_flag_cell (S, R, CLK, RST_N -> Q, Q_B, ILL), instantiated N times.
REQ-033 The round-robin selection SHALL be combinational logic inside rs_req_arbiter.

Verification
REQ-034 Reset, then S[2] one cycle -> PEND[2]=1 at edge 1; GNT=4'b0100, GNT_ID=2 at edge 2; DONE -> RELEASE, PEND[2]=0, PTR=3.
REQ-035 S=4'b1111 in one cycle from reset -> grants in the order 0,1,2,3, each ended by DONE; no requester granted twice.
REQ-036 S[1]=R[1]=1 in the same cycle -> PEND[1]=PEND_B[1]=0, ILLEGAL[1]=1 and held; a later S[1] -> PEND[1]=1 and a grant follows.
REQ-037 Grant to 0 with DONE held low, TMO=15 -> RELEASE after 15 GRANT cycles, one-cycle TMO_ERR, PTR=1.
REQ-038 R[0] during the grant to 0 -> RELEASE next cycle, PEND[0]=0; S[0] in the RELEASE cycle -> PEND[0] stays 1.
REQ-039 RST_N low mid-GRANT -> GNT=0, PEND=0, PEND_B=4'b1111 without waiting for a clock edge.
